// File: rtl/prores_pkg.sv
// Shared constants for the set_bit arbiter: requester indices,
// the "no owner" grant code, the size ceiling and the FSM state type.
package prores_pkg;

   localparam logic [1:0] REQ_HDR    = 2'd0;
   localparam logic [1:0] REQ_DC     = 2'd1;
   localparam logic [1:0] REQ_AC     = 2'd2;
   localparam logic [1:0] GRANT_NONE = 2'd3;

   localparam logic [6:0] MAX_SIZE = 7'd64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   function automatic logic [6:0] clip_size(input logic [6:0] s);
      return (s > MAX_SIZE) ? MAX_SIZE : s;
   endfunction

endpackage

// File: rtl/set_bit_beat_reg.sv
// One-entry output register feeding set_bit; clips the size, masks
// payload bits above the size and zeroes val/size for flush beats.
// Ports: clk, rst (sync, active-high), load + in_* (beat to capture),
// out_ready (downstream accept), enable/val/size/flush (registered beat).
module set_bit_beat_reg
   import prores_pkg::*;
#(
   parameter int VAL_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [VAL_WIDTH-1:0] in_val,
   input  logic [6:0]           in_size,
   input  logic                 in_flush,
   input  logic                 out_ready,
   output logic                 enable,
   output logic [VAL_WIDTH-1:0] val,
   output logic [6:0]           size,
   output logic                 flush
);

   logic [6:0]           size_c;
   logic [VAL_WIDTH-1:0] mask;

   // A flush carries no payload, so a zero size also zeroes the mask.
   always_comb begin
      size_c = in_flush ? 7'd0 : clip_size(in_size);
      mask   = '0;
      for (int i = 0; i < VAL_WIDTH; i++) begin
         mask[i] = (i < int'(size_c));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable <= 1'b0;
         val    <= '0;
         size   <= '0;
         flush  <= 1'b0;
      end else if (load) begin
         enable <= 1'b1;
         val    <= in_val & mask;
         size   <= size_c;
         flush  <= in_flush;
      end else if (out_ready) begin
         enable <= 1'b0;
      end
   end

endmodule

// File: rtl/set_bit_arbiter.sv
// Fixed-priority, packet-locked arbiter merging header/DC/AC bit beats
// into one set_bit stream, with a one-entry output register.
// Ports: CLOCK, RESET (sync, active-high); per-requester req_valid/
// req_ready/req_val/req_size_of_bit/req_last/req_flush; out_ready and
// output_* toward set_bit; grant (3 = none); total_bit_count.
module set_bit_arbiter
   import prores_pkg::*;
#(
   parameter int VAL_WIDTH = 64,
   parameter int NUM_REQ   = int'(REQ_AC) + 1
) (
   input  logic                         CLOCK,
   input  logic                         RESET,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*VAL_WIDTH-1:0] req_val,
   input  logic [NUM_REQ*7-1:0]         req_size_of_bit,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [NUM_REQ-1:0]           req_flush,
   input  logic                         out_ready,
   output logic                         output_enable,
   output logic [VAL_WIDTH-1:0]         output_val,
   output logic [6:0]                   output_size_of_bit,
   output logic                         output_flush,
   output logic [1:0]                   grant,
   output logic [31:0]                  total_bit_count
);

   arb_state_e           state_q;
   arb_state_e           state_d;
   logic [1:0]           grant_d;
   logic [1:0]           pick;
   logic                 slot_free;
   logic                 accept;
   logic                 load;
   logic [VAL_WIDTH-1:0] sel_val;
   logic [6:0]           sel_size;
   logic                 sel_last;
   logic                 sel_flush;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         grant   <= GRANT_NONE;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
      end
   end

   // Lowest index wins: scan downward so the last hit is the smallest.
   always_comb begin
      pick = GRANT_NONE;
      for (int i = NUM_REQ - 1; i >= int'(REQ_HDR); i--) begin
         if (req_valid[i]) pick = 2'(i);
      end
   end

   always_comb begin
      sel_val   = '0;
      sel_size  = '0;
      sel_last  = 1'b0;
      sel_flush = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == 2'(i)) begin
            sel_val   = req_val[i*VAL_WIDTH +: VAL_WIDTH];
            sel_size  = req_size_of_bit[i*7 +: 7];
            sel_last  = req_last[i];
            sel_flush = req_flush[i];
         end
      end
   end

   assign slot_free = !output_enable || out_ready;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant;
      req_ready = '0;
      accept    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (grant == 2'(i)) && slot_free && !RESET;
            end
            accept = |(req_ready & req_valid);
            if (accept && sel_last) begin
               state_d = ST_IDLE;
               grant_d = GRANT_NONE;
            end
         end
      endcase
   end

   // Empty non-flush beats are consumed but never reach set_bit.
   assign load = accept && (sel_flush || (sel_size != 7'd0));

   set_bit_beat_reg #(
      .VAL_WIDTH (VAL_WIDTH)
   ) u_beat (
      .clk       (CLOCK),
      .rst       (RESET),
      .load      (load),
      .in_val    (sel_val),
      .in_size   (sel_size),
      .in_flush  (sel_flush),
      .out_ready (out_ready),
      .enable    (output_enable),
      .val       (output_val),
      .size      (output_size_of_bit),
      .flush     (output_flush)
   );

   // Flush beats hold size 0, so they add nothing here.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         total_bit_count <= '0;
      end else if (output_enable && out_ready) begin
         total_bit_count <= total_bit_count + 32'(output_size_of_bit);
      end
   end

endmodule

// File: tb/tb_set_bit_arbiter.sv
// Self-checking bench for set_bit_arbiter: directed table, corner
// sequences and random traffic against a scoreboard model.
module tb_set_bit_arbiter;

   localparam int W = 64;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_val;
   logic [N*7-1:0] req_size;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_flush;
   logic           out_ready;
   logic           output_enable;
   logic [W-1:0]   output_val;
   logic [6:0]     output_size;
   logic           output_flush;
   logic [1:0]     grant;
   logic [31:0]    total_bit_count;

   always #5 clk = ~clk;

   set_bit_arbiter #(.VAL_WIDTH(W), .NUM_REQ(N)) dut (
      .CLOCK              (clk),
      .RESET              (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_val            (req_val),
      .req_size_of_bit    (req_size),
      .req_last           (req_last),
      .req_flush          (req_flush),
      .out_ready          (out_ready),
      .output_enable      (output_enable),
      .output_val         (output_val),
      .output_size_of_bit (output_size),
      .output_flush       (output_flush),
      .grant              (grant),
      .total_bit_count    (total_bit_count)
   );

   typedef struct {
      logic [63:0] val;
      logic [6:0]  size;
      logic        flush;
   } beat_t;

   typedef struct {
      logic [63:0] v;
      logic [6:0]  s;
      logic        f;
      logic        en;
      logic [63:0] ev;
      logic [6:0]  es;
      logic        ef;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Spec-level beat transform: clip to 64, keep low bits, flush empty.
   function automatic beat_t to_out(input logic [63:0] v,
                                    input logic [6:0] s, input logic f);
      beat_t b;
      int    n;
      n = (s > 7'd64) ? 64 : int'(s);
      if (f) begin
         b.val = '0; b.size = '0; b.flush = 1'b1;
      end else begin
         b.val   = (n >= 64) ? v : (v & ((64'd1 << n) - 64'd1));
         b.size  = 7'(n);
         b.flush = 1'b0;
      end
      return b;
   endfunction

   // Scoreboard: at most one beat in flight, one packet owner at a time.
   beat_t       exp_q[$];
   logic [31:0] m_cnt;
   logic        m_busy;
   int          m_owner;
   logic [2:0]  acc_m;
   logic [2:0]  exp_rdy;
   beat_t       nb;

   always @(posedge clk) begin
      acc_m = req_valid & req_ready;
      if (rst) begin
         chk("ready_in_reset", 64'(req_ready), 64'd0);
         exp_q.delete();
         m_cnt   = '0;
         m_busy  = 1'b0;
         m_owner = 3;
      end else begin
         chk("grant", 64'(grant), m_busy ? 64'(m_owner) : 64'd3);
         exp_rdy = (m_busy && (!output_enable || out_ready))
                   ? 3'(1 << m_owner) : 3'd0;
         chk("ready", 64'(req_ready), 64'(exp_rdy));
         chk("enable", 64'(output_enable), 64'(exp_q.size() != 0));
         chk("count", 64'(total_bit_count), 64'(m_cnt));
         if (output_enable === 1'b1 && exp_q.size() != 0) begin
            chk("out_val", output_val, exp_q[0].val);
            chk("out_size", 64'(output_size), 64'(exp_q[0].size));
            chk("out_flush", 64'(output_flush), 64'(exp_q[0].flush));
            if (out_ready) begin
               m_cnt = m_cnt + 32'(exp_q[0].size);
               void'(exp_q.pop_front());
            end
         end
         for (int r = 0; r < N; r++) begin
            if (acc_m[r]) begin
               nb = to_out(req_val[r*W +: W], req_size[r*7 +: 7],
                           req_flush[r]);
               if (nb.flush || nb.size != 0) exp_q.push_back(nb);
            end
         end
         if (!m_busy) begin
            if (|req_valid) begin
               for (int r = N - 1; r >= 0; r--)
                  if (req_valid[r]) m_owner = r;
               m_busy = 1'b1;
            end
         end else if (acc_m[m_owner] && req_last[m_owner]) begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      out_ready = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   // Offer one beat; returns 1 time unit after the accepting edge.
   task automatic send(input int r, input logic [63:0] v,
                       input logic [6:0] s, input logic l, input logic f);
      int n;
      req_val[r*W +: W]  = v;
      req_size[r*7 +: 7] = s;
      req_last[r]        = l;
      req_flush[r]       = f;
      req_valid[r]       = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready[r] !== 1'b1) begin
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout req %0d: got ready 0 expected 1", r);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   vec_t       vt[10];
   logic [2:0] acc_d;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_val   = '0;
      req_size  = '0;
      req_last  = '0;
      req_flush = '0;
      out_ready = 1'b1;

      vt[0] = '{ONES, 7'd5, 1'b0, 1'b1, 64'h1F, 7'd5, 1'b0};
      vt[1] = '{ONES, 7'd9, 1'b0, 1'b1, 64'h1FF, 7'd9, 1'b0};
      vt[2] = '{ONES, 7'd64, 1'b0, 1'b1, ONES, 7'd64, 1'b0};
      vt[3] = '{ONES, 7'd70, 1'b0, 1'b1, ONES, 7'd64, 1'b0};
      vt[4] = '{ONES, 7'd127, 1'b0, 1'b1, ONES, 7'd64, 1'b0};
      vt[5] = '{ONES, 7'd0, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
      vt[6] = '{ONES, 7'd12, 1'b1, 1'b1, 64'h0, 7'd0, 1'b1};
      vt[7] = '{64'hFFFF_FFFF_FFFF_FFFE, 7'd1, 1'b0, 1'b1,
                64'h0, 7'd1, 1'b0};
      vt[8] = '{ONES, 7'd63, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 7'd63, 1'b0};
      vt[9] = '{64'h1234_5678_9ABC_DEF0, 7'd32, 1'b0, 1'b1,
                64'h9ABC_DEF0, 7'd32, 1'b0};

      do_reset();
      chk("reset_grant", 64'(grant), 64'd3);
      chk("reset_enable", 64'(output_enable), 64'd0);
      chk("reset_count", 64'(total_bit_count), 64'd0);

      for (int k = 0; k < 10; k++) begin
         send(1, vt[k].v, vt[k].s, 1'b1, vt[k].f);
         chk($sformatf("vec%0d_en", k), 64'(output_enable), 64'(vt[k].en));
         if (vt[k].en) begin
            chk($sformatf("vec%0d_val", k), output_val, vt[k].ev);
            chk($sformatf("vec%0d_size", k), 64'(output_size),
                64'(vt[k].es));
            chk($sformatf("vec%0d_flush", k), 64'(output_flush),
                64'(vt[k].ef));
         end
         tick(2);
      end

      // DC three-beat packet
      do_reset();
      send(1, ONES, 7'd5, 1'b0, 1'b0);
      chk("dc_b0", output_val, 64'h1F);
      send(1, ONES, 7'd9, 1'b0, 1'b0);
      chk("dc_b1", output_val, 64'h1FF);
      send(1, ONES, 7'd64, 1'b1, 1'b0);
      chk("dc_b2", output_val, ONES);
      tick(3);
      chk("dc_count", 64'(total_bit_count), 64'd78);

      // header and AC contend in the same idle cycle
      do_reset();
      req_val[2*W +: W]  = ONES;
      req_size[2*7 +: 7] = 7'd8;
      req_last[2]        = 1'b1;
      req_flush[2]       = 1'b0;
      req_valid[2]       = 1'b1;
      send(0, ONES, 7'd4, 1'b0, 1'b0);
      chk("prio_grant_hdr", 64'(grant), 64'd0);
      send(0, ONES, 7'd4, 1'b1, 1'b0);
      chk("prio_gap", 64'(grant), 64'd3);
      tick(1);
      chk("prio_grant_ac", 64'(grant), 64'd2);
      send(2, ONES, 7'd8, 1'b1, 1'b0);
      chk("prio_ac_val", output_val, 64'hFF);
      tick(3);
      chk("prio_count", 64'(total_bit_count), 64'd16);

      // AC flush, then oversize clip
      do_reset();
      send(2, ONES, 7'd20, 1'b1, 1'b1);
      chk("flush_flag", 64'(output_flush), 64'd1);
      chk("flush_val", output_val, 64'd0);
      chk("flush_size", 64'(output_size), 64'd0);
      tick(3);
      chk("flush_count", 64'(total_bit_count), 64'd0);
      send(1, ONES, 7'd70, 1'b1, 1'b0);
      chk("clip_size", 64'(output_size), 64'd64);
      tick(3);
      chk("clip_count", 64'(total_bit_count), 64'd64);

      // backpressure for 4 cycles mid-packet
      send(1, 64'hDEAD_BEEF_CAFE_F00D, 7'd16, 1'b0, 1'b0);
      out_ready          = 1'b0;
      req_val[1*W +: W]  = 64'h0123_4567_89AB_CDEF;
      req_size[1*7 +: 7] = 7'd24;
      req_last[1]        = 1'b1;
      req_flush[1]       = 1'b0;
      req_valid[1]       = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_ready", 64'(req_ready[1]), 64'd0);
         chk("bp_enable", 64'(output_enable), 64'd1);
         chk("bp_hold", output_val, 64'hF00D);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(1, 64'h0123_4567_89AB_CDEF, 7'd24, 1'b1, 1'b0);
      chk("bp_next", output_val, 64'hAB_CDEF);
      tick(3);
      chk("bp_count", 64'(total_bit_count), 64'd104);

      // reset with a beat stuck in the output register
      out_ready = 1'b0;
      send(1, ONES, 7'd10, 1'b0, 1'b0);
      chk("pend_enable", 64'(output_enable), 64'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_enable", 64'(output_enable), 64'd0);
      chk("rst_val", output_val, 64'd0);
      chk("rst_size", 64'(output_size), 64'd0);
      chk("rst_flush", 64'(output_flush), 64'd0);
      chk("rst_grant", 64'(grant), 64'd3);
      chk("rst_count", 64'(total_bit_count), 64'd0);
      out_ready = 1'b1;
      tick(3);
      chk("rst_no_emit", 64'(output_enable), 64'd0);

      // random traffic; a held beat stays stable until accepted
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc_d = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int r = 0; r < N; r++) begin
            if (!req_valid[r] || acc_d[r]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_val[r*W +: W]  = {$urandom, $urandom};
                  req_size[r*7 +: 7] = 7'($urandom_range(0, 80));
                  req_last[r]        = ($urandom_range(0, 3) == 0);
                  req_flush[r]       = ($urandom_range(0, 9) == 0);
                  req_valid[r]       = 1'b1;
               end else begin
                  req_valid[r] = 1'b0;
               end
            end
         end
         out_ready = ($urandom_range(0, 9) < 7);
      end
      req_valid = '0;
      out_ready = 1'b1;
      tick(5);
      chk("drain_enable", 64'(output_enable), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/set_bit_arbiter.md
SET_BIT_ARBITER -- requirements
Module: set_bit_arbiter

Interface
REQ-001 Parameter VAL_WIDTH, default 64, SHALL set the bit-payload width per beat.
REQ-002 Parameter NUM_REQ, default 3, SHALL set the requester count: index 0 header, 1 DC output, 2 AC output.
REQ-003 CLOCK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  SHALL flag a beat offered by each requester.
REQ-006 req_ready  out  NUM_REQ  SHALL flag beat acceptance per requester.
REQ-007 req_val  in  NUM_REQ x VAL_WIDTH  SHALL carry right-aligned bits per requester.
REQ-008 req_size_of_bit  in  NUM_REQ x 7  SHALL carry the valid bit count, 0..64.
REQ-009 req_last  in  NUM_REQ  SHALL mark the final beat of a requester's packet.
REQ-010 req_flush  in  NUM_REQ  SHALL request a byte-align flush, with val and size ignored.
REQ-011 out_ready  in  1  SHALL flag that set_bit accepts the output beat.
REQ-012 output_enable / output_val / output_size_of_bit / output_flush  out  1/VAL_WIDTH/7/1  SHALL drive the set_bit enable/val/size_of_bit/flush_bit inputs.
REQ-013 grant  out  2  SHALL show the current owner, with 3 meaning none.
REQ-014 total_bit_count  out  32  SHALL count bits delivered downstream.

Function
REQ-015 FSM states SHALL be IDLE and BUSY, plus a one-entry output register.
REQ-016 IDLE: if any req_valid is set, the arbiter SHALL latch the lowest-index valid requester into grant and enter BUSY next cycle; no beat is accepted in the arbitration cycle.
REQ-017 BUSY: req_ready[i] SHALL equal (i==grant) && (!output_enable || out_ready); all other ready bits SHALL be 0.
REQ-018 An accepted beat SHALL appear on the output registers the following cycle, giving 1-cycle latency.
REQ-019 output_enable SHALL stay high and the output registers SHALL hold while out_ready=0; enable SHALL drop the cycle after a transfer unless a new beat is loaded.
REQ-020 output_val bits at or above output_size_of_bit SHALL be forced to 0.
REQ-021 A size_of_bit above 64 SHALL be clipped to 64.
REQ-022 A beat with size 0 and flush=0 SHALL be accepted and dropped, with no output_enable.
REQ-023 A flush beat SHALL output output_flush=1, val=0, size=0.
REQ-024 Grant SHALL be locked until a beat with req_last is accepted; the state then returns to IDLE next cycle, and grant reads 3 in IDLE.
REQ-025 If the owner drops req_valid mid-packet, grant SHALL be held indefinitely with no timeout.
REQ-026 Requests arriving during BUSY SHALL wait; re-arbitration SHALL use fixed priority with no round-robin.
REQ-027 total_bit_count SHALL add output_size_of_bit on each output_enable && out_ready, wrap modulo 2^32, and add nothing for flush beats.

Reset
REQ-028 On RESET the arbiter SHALL enter IDLE and clear grant=3, req_ready=0, all output_* = 0 and total_bit_count=0.
REQ-029 An in-flight beat SHALL be discarded when RESET asserts mid-packet.
REQ-030 RESET SHALL override all other inputs in the same cycle.

Structure
REQ-031 Requester index constants (REQ_HDR=0, REQ_DC=1, REQ_AC=2), GRANT_NONE=3 and the state enum SHALL live in the shared prores package.
REQ-032 The output register plus masking SHALL be one sub-module, set_bit_beat_reg; arbitration and the FSM stay in the top.

Verification
REQ-033 DC alone sends 3 beats (size 5, 9, 64 with val all-ones, last on the third) -> outputs appear at +1 cycle each with vals 0x1F, 0x1FF, all-ones, and total_bit_count=78.
REQ-034 Header and AC valid in the same IDLE cycle -> grant=0 first; AC is served only after the header's last beat, with grant=3 for one cycle between packets.
REQ-035 out_ready held low 4 cycles during a DC packet -> output held stable, req_ready[1]=0, and no beat lost or duplicated.
REQ-036 AC sends a flush beat with last -> output_flush=1, val=0, size=0, and total_bit_count unchanged.
REQ-037 Size 70 with val all-ones -> output_size_of_bit=64 and count +64.
REQ-038 RESET asserted mid-packet with a beat pending -> next cycle all outputs 0, grant=3, count=0, and the pending beat is never emitted.
